multicycle_ctrl: RTL

Parametrised next-generation sequencer for the multicycle CPU datapath. It produces the one-hot stage enables PC/ID/EX/MEM/WB per instruction and skips stages per instruction class. It adds a memory ready/wait handshake with a timeout, branch/jump redirect, HALT/resume, an error state and a retired-instruction counter. It sits between the decoder (op_class) and the datapath stage registers.

---
 rtl/ctrl_pkg.sv | 39 +++
 rtl/ctrl_field_decode.sv | 65 ++++++
 rtl/multicycle_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle CPU sequencer.
//   - op_class encodings produced by the instruction decoder
//   - sequencer state encodings (also exported on state_o for debug)
//   - bit positions inside the one-hot stage_en vector
//   - write-back source select codes carried on wb_ctrl
package ctrl_pkg;

  localparam logic [2:0] OP_ALU_R  = 3'd0;
  localparam logic [2:0] OP_ALU_I  = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_STORE  = 3'd3;
  localparam logic [2:0] OP_BRANCH = 3'd4;
  localparam logic [2:0] OP_JUMP   = 3'd5;
  localparam logic [2:0] OP_NOP    = 3'd6;
  localparam logic [2:0] OP_HALT   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam int STG_PC  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam logic [1:0] WB_NONE = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_MEM  = 2'b10;
  localparam logic [1:0] WB_LINK = 2'b11;

endpackage

// File: rtl/ctrl_field_decode.sv
// ctrl_field_decode: purely combinational op_class -> control field decode.
// The top level registers these outputs while the sequencer is in DECODE.
// Ports:
//   op_class  in  OPC_W  instruction class from the decoder
//   imm_en    out 1      immediate operand select
//   l_or_s    out 1      1 = store, 0 = load
//   wb_ctrl   out 2      write-back source select
//   is_mem    out 1      instruction needs the MEM stage (LOAD/STORE)
//   is_jump   out 1      unconditional jump
//   is_branch out 1      conditional branch
//   is_nop    out 1      NOP, or any encoding outside the defined set
//   is_halt   out 1      HALT
module ctrl_field_decode
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 3
) (
  input  logic [OPC_W-1:0] op_class,
  output logic             imm_en,
  output logic             l_or_s,
  output logic [1:0]       wb_ctrl,
  output logic             is_mem,
  output logic             is_jump,
  output logic             is_branch,
  output logic             is_nop,
  output logic             is_halt
);

  // Class decode; undefined encodings (wider op_class) fall into the NOP arm.
  always_comb begin
    imm_en    = 1'b0;
    l_or_s    = 1'b0;
    wb_ctrl   = WB_NONE;
    is_mem    = 1'b0;
    is_jump   = 1'b0;
    is_branch = 1'b0;
    is_nop    = 1'b0;
    is_halt   = 1'b0;
    case (op_class)
      OPC_W'(OP_ALU_R): wb_ctrl = WB_ALU;
      OPC_W'(OP_ALU_I): begin
        imm_en  = 1'b1;
        wb_ctrl = WB_ALU;
      end
      OPC_W'(OP_LOAD): begin
        imm_en  = 1'b1;
        wb_ctrl = WB_MEM;
        is_mem  = 1'b1;
      end
      OPC_W'(OP_STORE): begin
        imm_en = 1'b1;
        l_or_s = 1'b1;
        is_mem = 1'b1;
      end
      OPC_W'(OP_BRANCH): is_branch = 1'b1;
      OPC_W'(OP_JUMP): begin
        is_jump = 1'b1;
        wb_ctrl = WB_LINK;
      end
      OPC_W'(OP_HALT): is_halt = 1'b1;
      default: is_nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: stage sequencer for the multicycle CPU datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB per instruction, skipping stages by class,
// with a memory ready handshake plus timeout, PC redirect strobe, HALT/resume,
// a sticky error state and a wrapping retired-instruction counter.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   op_class      instruction class, sampled in DECODE
//   branch_taken  branch condition, used in EXEC
//   mem_ready     memory access complete, sampled in MEM
//   resume        leaves HALTED
//   stage_en      one-hot enables [0]PC [1]ID [2]EX [3]MEM [4]WB
//   mem_req       high throughout MEM
//   jump_en       PC redirect strobe (EXEC only)
//   imm_en, l_or_s, wb_ctrl  control fields latched in DECODE
//   retire_cnt    retired instruction count
//   halted, err   status flags
//   state_o       current state for debug
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPC_W       = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] op_class,
  input  logic             branch_taken,
  input  logic             mem_ready,
  input  logic             resume,
  output logic [4:0]       stage_en,
  output logic             mem_req,
  output logic             jump_en,
  output logic             imm_en,
  output logic             l_or_s,
  output logic [1:0]       wb_ctrl,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             halted,
  output logic             err,
  output logic [2:0]       state_o
);

  localparam logic [7:0] TMO_LIM = 8'(MEM_TIMEOUT);

  state_t           state_r;
  logic             imm_en_r;
  logic             l_or_s_r;
  logic [1:0]       wb_ctrl_r;
  logic             is_mem_r;
  logic             is_jump_r;
  logic             is_branch_r;
  logic [CNT_W-1:0] retire_cnt_r;
  logic [7:0]       tmo_cnt_r;
  logic [4:0]       stage_en_s;

  logic       dec_imm_en_s;
  logic       dec_l_or_s_s;
  logic [1:0] dec_wb_ctrl_s;
  logic       dec_is_mem_s;
  logic       dec_is_jump_s;
  logic       dec_is_branch_s;
  logic       dec_is_nop_s;
  logic       dec_is_halt_s;

  ctrl_field_decode #(.OPC_W(OPC_W)) u_decode (
    .op_class  (op_class),
    .imm_en    (dec_imm_en_s),
    .l_or_s    (dec_l_or_s_s),
    .wb_ctrl   (dec_wb_ctrl_s),
    .is_mem    (dec_is_mem_s),
    .is_jump   (dec_is_jump_s),
    .is_branch (dec_is_branch_s),
    .is_nop    (dec_is_nop_s),
    .is_halt   (dec_is_halt_s)
  );

  // Sequencer state, latched control fields, retire and MEM timeout counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      imm_en_r     <= 1'b0;
      l_or_s_r     <= 1'b0;
      wb_ctrl_r    <= WB_NONE;
      is_mem_r     <= 1'b0;
      is_jump_r    <= 1'b0;
      is_branch_r  <= 1'b0;
      retire_cnt_r <= '0;
      tmo_cnt_r    <= 8'd0;
    end else begin
      case (state_r)
        S_IDLE:  state_r <= S_FETCH;
        S_FETCH: state_r <= S_DECODE;
        S_DECODE: begin
          imm_en_r    <= dec_imm_en_s;
          l_or_s_r    <= dec_l_or_s_s;
          wb_ctrl_r   <= dec_wb_ctrl_s;
          is_mem_r    <= dec_is_mem_s;
          is_jump_r   <= dec_is_jump_s;
          is_branch_r <= dec_is_branch_s;
          if (dec_is_halt_s) begin
            state_r      <= S_HALTED;
            retire_cnt_r <= retire_cnt_r + CNT_W'(1'b1);
          end else if (dec_is_nop_s) begin
            state_r      <= S_FETCH;
            retire_cnt_r <= retire_cnt_r + CNT_W'(1'b1);
          end else begin
            state_r <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_mem_r) begin
            state_r <= S_MEM;
          end else if (is_jump_r || is_branch_r) begin
            state_r      <= S_FETCH;
            retire_cnt_r <= retire_cnt_r + CNT_W'(1'b1);
          end else begin
            state_r <= S_WB;
          end
        end
        S_MEM: begin
          // ready is checked first so it wins over a timeout in the same cycle
          if (mem_ready) begin
            tmo_cnt_r <= 8'd0;
            if (l_or_s_r) begin
              state_r      <= S_FETCH;
              retire_cnt_r <= retire_cnt_r + CNT_W'(1'b1);
            end else begin
              state_r <= S_WB;
            end
          end else if (tmo_cnt_r + 8'd1 == TMO_LIM) begin
            tmo_cnt_r <= 8'd0;
            state_r   <= S_ERROR;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        S_WB: begin
          state_r      <= S_FETCH;
          retire_cnt_r <= retire_cnt_r + CNT_W'(1'b1);
        end
        S_HALTED: begin
          if (resume) begin
            state_r <= S_FETCH;
          end else begin
            state_r <= S_HALTED;
          end
        end
        S_ERROR: state_r <= S_ERROR;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Moore stage-enable decode from the state register.
  always_comb begin
    stage_en_s = 5'b00000;
    case (state_r)
      S_FETCH:  stage_en_s[STG_PC]  = 1'b1;
      S_DECODE: stage_en_s[STG_ID]  = 1'b1;
      S_EXEC:   stage_en_s[STG_EX]  = 1'b1;
      S_MEM:    stage_en_s[STG_MEM] = 1'b1;
      S_WB:     stage_en_s[STG_WB]  = 1'b1;
      default:  stage_en_s = 5'b00000;
    endcase
  end

  assign stage_en   = stage_en_s;
  assign mem_req    = (state_r == S_MEM);
  // branch_taken is only meaningful during EXEC, so the strobe qualifies it there
  assign jump_en    = (state_r == S_EXEC) && (is_jump_r || (is_branch_r && branch_taken));
  assign imm_en     = imm_en_r;
  assign l_or_s     = l_or_s_r;
  assign wb_ctrl    = wb_ctrl_r;
  assign retire_cnt = retire_cnt_r;
  assign halted     = (state_r == S_HALTED);
  assign err        = (state_r == S_ERROR);
  assign state_o    = state_r;

endmodule
